system_pio_multi_out: RTL

//  Parametrised Avalon-MM multi-channel output register bank for the front-end control PIOs (SPI bit counts, pulser config).

---
 rtl/system_pio_multi_out.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/system_pio_multi_out.sv
// Multi-channel double-buffered Avalon-MM output register bank.
// Shadow registers are copied to out_port atomically on commit, announced by a fixed-length update_strobe.
module system_pio_multi_out #(
    parameter int               WIDTH     = 8,
    parameter int               NUM_CH    = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               PULSE_LEN = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic [NUM_CH*WIDTH-1:0] out_port,
    output logic                    update_strobe,
    output logic                    busy
);

    localparam int CNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN - 1);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_PULSE = 1'b1;

    localparam logic [3:0] ADDR_CTRL   = 4'd8;
    localparam logic [3:0] ADDR_COMMIT = 4'd9;
    localparam logic [3:0] ADDR_STATUS = 4'd10;
    localparam logic [3:0] ADDR_OUT    = 4'd11;

    logic [WIDTH-1:0]        shadow_r     [NUM_CH];
    logic [WIDTH-1:0]        shadow_nxt_s [NUM_CH];
    logic [NUM_CH*WIDTH-1:0] shadow_pack_s;
    logic [NUM_CH*WIDTH-1:0] out_r;
    logic [31:0]             ctrl_r;
    logic [0:0]              state_r;
    logic [0:0]              state_nxt_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W-1:0]        cnt_nxt_s;
    logic                    pending_r;
    logic                    pending_nxt_s;
    logic                    strobe_r;
    logic                    busy_r;
    logic                    load_out_s;
    logic                    wr_s;
    logic                    shadow_wr_s;
    logic                    commit_req_s;
    logic [WIDTH-1:0]        out_sel_s;
    logic [31:0]             rd_s;

    assign wr_s = chipselect & ~write_n;

    // Shadow write decode; the packed copy already includes a same-cycle write so commits see it.
    always_comb begin
        shadow_wr_s   = 1'b0;
        shadow_pack_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_s && (address == 4'(i))) begin
                shadow_nxt_s[i] = writedata[WIDTH-1:0];
                shadow_wr_s     = 1'b1;
            end else begin
                shadow_nxt_s[i] = shadow_r[i];
            end
            shadow_pack_s[i*WIDTH +: WIDTH] = shadow_nxt_s[i];
        end
    end

    assign commit_req_s = (wr_s && (address == ADDR_COMMIT)) | (shadow_wr_s & ctrl_r[0]);

    // Commit FSM: a request arriving while the pulse runs is merged into one pending commit.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        pending_nxt_s = pending_r;
        load_out_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (commit_req_s) begin
                    load_out_s  = 1'b1;
                    cnt_nxt_s   = CNT_LOAD;
                    state_nxt_s = ST_PULSE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PULSE: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    // Back-to-back commit keeps the strobe high with no gap.
                    if (pending_r | commit_req_s) begin
                        load_out_s    = 1'b1;
                        cnt_nxt_s     = CNT_LOAD;
                        pending_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                    if (commit_req_s) begin
                        pending_nxt_s = 1'b1;
                    end else begin
                        pending_nxt_s = pending_r;
                    end
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                pending_nxt_s = 1'b0;
                cnt_nxt_s     = {CNT_W{1'b0}};
            end
        endcase
    end

    // Register bank, FSM state and registered strobe/busy outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_r[i] <= RESET_VAL;
            end
            out_r     <= {NUM_CH{RESET_VAL}};
            ctrl_r    <= 32'd0;
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            pending_r <= 1'b0;
            strobe_r  <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_r[i] <= shadow_nxt_s[i];
            end
            if (load_out_s) begin
                out_r <= shadow_pack_s;
            end else begin
                out_r <= out_r;
            end
            if (wr_s && (address == ADDR_CTRL)) begin
                ctrl_r <= writedata;
            end else begin
                ctrl_r <= ctrl_r;
            end
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            pending_r <= pending_nxt_s;
            strobe_r  <= (state_nxt_s == ST_PULSE);
            busy_r    <= (state_nxt_s == ST_PULSE) | pending_nxt_s;
        end
    end

    // Channel selected for OUT readback; out-of-range selects read zero.
    always_comb begin
        out_sel_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ctrl_r[6:4] == 3'(i)) begin
                out_sel_s = out_r[i*WIDTH +: WIDTH];
            end else begin
                out_sel_s = out_sel_s;
            end
        end
    end

    // Zero-wait read mux.
    always_comb begin
        rd_s = 32'd0;
        if (address < 4'(NUM_CH)) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (address == 4'(i)) begin
                    rd_s = 32'(shadow_r[i]);
                end else begin
                    rd_s = rd_s;
                end
            end
        end else begin
            case (address)
                ADDR_CTRL:   rd_s = ctrl_r;
                ADDR_STATUS: rd_s = {30'd0, pending_r, busy_r};
                ADDR_OUT:    rd_s = 32'(out_sel_s);
                default:     rd_s = 32'd0;
            endcase
        end
    end

    assign readdata      = rd_s;
    assign out_port      = out_r;
    assign update_strobe = strobe_r;
    assign busy          = busy_r;

endmodule
